// File: rtl/pf_ddr4_odt_dly_ctrl_if.sv
// rtl/pf_ddr4_odt_dly_ctrl_if.sv - request/status bus between training logic and the ODT delay sequencer
interface pf_ddr4_odt_dly_ctrl_if #(
   parameter int TAP_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [TAP_W-1:0] req_tap;
   logic             req_load;
   logic             busy;
   logic             done;
   logic             err;
   logic [TAP_W-1:0] cur_tap;

   modport master (
      output req_valid, req_tap, req_load,
      input  req_ready, busy, done, err, cur_tap
   );

   modport slave (
      input  req_valid, req_tap, req_load,
      output req_ready, busy, done, err, cur_tap
   );
endinterface

// File: rtl/pf_ddr4_odt_dly_ctrl.sv
// rtl/pf_ddr4_odt_dly_ctrl.sv - ODT lane IOD delay-line sequencer; optional ODT gating under `PF_DDR4_ODT_GATE_EN
module pf_ddr4_odt_dly_ctrl #(
   parameter int TAP_W    = 8,
   parameter int MAX_TAP  = 127,
   parameter int LOAD_TAP = 1,
   parameter int MOVE_GAP = 4,
   parameter int SETTLE   = 8
) (
   input  logic                         i_fab_clk,
   input  logic                         i_sync_rst,
   pf_ddr4_odt_dly_ctrl_if.slave        s_req,
   input  logic                         i_odt_en_in,
   output logic                         o_odt_en_0,
   output logic                         o_delay_line_move_0,
   output logic                         o_delay_line_direction_0,
   output logic                         o_delay_line_load_0,
   input  logic                         i_delay_line_out_of_range_0
);
   localparam int CNT_MAX = (MOVE_GAP > SETTLE) ? MOVE_GAP : SETTLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TAP_W-1:0] L_MAX_TAP  = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] L_LOAD_TAP = TAP_W'(LOAD_TAP);
   localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(MOVE_GAP - 1);
   localparam logic [CNT_W-1:0] L_SET_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_LOAD, S_PREP, S_MOVE, S_GAP, S_SETTLE, S_FIN
   } state_t;

   state_t           r_state;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [TAP_W-1:0] r_cur;
   logic [TAP_W-1:0] r_tgt;
   logic             r_ld;
   logic             r_loaded;
   logic             r_move;
   logic             r_load;
   logic             r_dir;
   logic [CNT_W-1:0] r_cnt;
   logic             r_odt_in;

   logic [TAP_W-1:0] w_cur_step;
   logic [TAP_W-1:0] w_gap_cur;
   logic             w_gap_first;
   logic             w_at_limit;

   // Next tap after a MOVE, and the tap value seen at the end of the current GAP cycle
   assign w_cur_step  = r_dir ? (r_cur + TAP_W'(1)) : (r_cur - TAP_W'(1));
   assign w_gap_first = (r_cnt == L_GAP_LAST);
   assign w_gap_cur   = w_gap_first ? w_cur_step : r_cur;
   assign w_at_limit  = r_dir ? (r_cur >= L_MAX_TAP) : (r_cur == '0);

   assign s_req.req_ready = r_ready;
   assign s_req.busy      = r_busy;
   assign s_req.done      = r_done;
   assign s_req.err       = r_err;
   assign s_req.cur_tap   = r_cur;

   assign o_delay_line_move_0      = r_move;
   assign o_delay_line_load_0      = r_load;
   assign o_delay_line_direction_0 = r_dir;

   // Sequencer: accept, range-check, optional LOAD, paced MOVEs, settle, done pulse
   always_ff @(posedge i_fab_clk) begin
      if (i_sync_rst) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_cur    <= L_LOAD_TAP;
         r_tgt    <= '0;
         r_ld     <= 1'b0;
         r_loaded <= 1'b0;
         r_move   <= 1'b0;
         r_load   <= 1'b0;
         r_dir    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_move <= 1'b0;
         r_load <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (s_req.req_valid && r_ready) begin
                  r_tgt    <= s_req.req_tap;
                  r_ld     <= s_req.req_load;
                  r_loaded <= 1'b0;
                  r_err    <= 1'b0;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               // Without a LOAD the first MOVE leaves straight from here; an in-place target still visits PREP
               if (r_tgt > L_MAX_TAP) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else if (r_ld) begin
                  r_load  <= 1'b1;
                  r_state <= S_LOAD;
               end else if (r_tgt != r_cur) begin
                  r_dir   <= (r_tgt > r_cur);
                  r_move  <= 1'b1;
                  r_state <= S_MOVE;
               end else begin
                  r_state <= S_PREP;
               end
            end
            S_LOAD: begin
               r_cur    <= L_LOAD_TAP;
               r_loaded <= 1'b1;
               r_state  <= S_PREP;
            end
            S_PREP: begin
               if (r_tgt == r_cur) begin
                  if (r_loaded) begin
                     r_cnt   <= L_SET_LAST;
                     r_state <= S_SETTLE;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end
               end else begin
                  r_dir   <= (r_tgt > r_cur);
                  r_move  <= 1'b1;
                  r_state <= S_MOVE;
               end
            end
            S_MOVE: begin
               r_cnt   <= L_GAP_LAST;
               r_state <= S_GAP;
            end
            S_GAP: begin
               if (w_gap_first && (i_delay_line_out_of_range_0 || w_at_limit)) begin
                  r_err   <= 1'b1;
                  r_cnt   <= L_SET_LAST;
                  r_state <= S_SETTLE;
               end else begin
                  if (w_gap_first) begin
                     r_cur <= w_cur_step;
                  end
                  if (r_cnt == '0) begin
                     if (w_gap_cur != r_tgt) begin
                        r_move  <= 1'b1;
                        r_state <= S_MOVE;
                     end else begin
                        r_cnt   <= L_SET_LAST;
                        r_state <= S_SETTLE;
                     end
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_FIN: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // One-cycle retiming of the PHY ODT enable toward the IOD
   always_ff @(posedge i_fab_clk) begin
      if (i_sync_rst) begin
         r_odt_in <= 1'b0;
      end else begin
         r_odt_in <= i_odt_en_in;
      end
   end

`ifdef PF_DDR4_ODT_GATE_EN
   logic w_gate;
   // ODT held off from the LOAD/first MOVE cycle through the last SETTLE cycle
   assign w_gate = (r_state == S_LOAD) || (r_state == S_MOVE) || (r_state == S_GAP) ||
                   (r_state == S_SETTLE) || ((r_state == S_PREP) && r_loaded);
   assign o_odt_en_0 = r_odt_in & ~w_gate;
`else
   assign o_odt_en_0 = r_odt_in;
`endif
endmodule

// File: tb/tb_pf_ddr4_odt_dly_ctrl.sv
// tb/tb_pf_ddr4_odt_dly_ctrl.sv - self-checking bench for the ODT delay-line sequencer
module tb_pf_ddr4_odt_dly_ctrl;
   localparam int TAP_W    = 8;
   localparam int MAX_TAP  = 127;
   localparam int LOAD_TAP = 1;
   localparam int MOVE_GAP = 4;
   localparam int SETTLE   = 8;
`ifdef PF_DDR4_ODT_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic odt_in = 1'b0;
   logic odt_out;
   logic mv;
   logic dir;
   logic ld;
   logic oor = 1'b0;

   int total = 0;
   int bad   = 0;
   int m_cur;
   int c;
   int moves;

   pf_ddr4_odt_dly_ctrl_if #(.TAP_W(TAP_W)) bus ();

   pf_ddr4_odt_dly_ctrl #(
      .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP),
      .MOVE_GAP(MOVE_GAP), .SETTLE(SETTLE)
   ) dut (
      .i_fab_clk                   (clk),
      .i_sync_rst                  (rst),
      .s_req                       (bus),
      .i_odt_en_in                 (odt_in),
      .o_odt_en_0                  (odt_out),
      .o_delay_line_move_0         (mv),
      .o_delay_line_direction_0    (dir),
      .o_delay_line_load_0         (ld),
      .i_delay_line_out_of_range_0 (oor)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One request; expectations come from the timing rules, not from the DUT
   task automatic run_req(input int tgt, input bit rld, input int oor_k);
      int start, n, first, e_done, e_moves, e_cur, ws, cyc, mcnt, lcnt;
      bit e_err, e_dir, over, seen_done, prev_in, exp_odt;
      over    = (tgt > MAX_TAP);
      start   = rld ? LOAD_TAP : m_cur;
      n       = (tgt > start) ? (tgt - start) : (start - tgt);
      e_dir   = (tgt > start);
      first   = rld ? 4 : 2;
      e_err   = over;
      e_moves = 0;
      e_cur   = m_cur;
      ws      = 0;
      if (over) begin
         e_done = 2;
      end else begin
         e_cur = start;
         if (rld || n > 0) ws = 2;
         if (n == 0) begin
            e_done = rld ? (4 + SETTLE) : 3;
         end else if (oor_k >= 1 && oor_k <= n) begin
            e_moves = oor_k;
            e_err   = 1'b1;
            e_cur   = e_dir ? (start + oor_k - 1) : (start - (oor_k - 1));
            e_done  = first + (MOVE_GAP + 1) * (oor_k - 1) + 2 + SETTLE;
         end else begin
            e_moves = n;
            e_cur   = tgt;
            e_done  = first + (MOVE_GAP + 1) * (n - 1) + MOVE_GAP + SETTLE + 1;
         end
      end

      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_tap   = TAP_W'(tgt);
      bus.req_load  = rld;
      prev_in       = 1'($urandom_range(0, 1));
      odt_in        = prev_in;
      @(posedge clk);
      cyc = 0; mcnt = 0; lcnt = 0; seen_done = 1'b0;
      while (!seen_done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk("busy_c1", bus.busy, 1);
            chk("ready_c1", bus.req_ready, 0);
            chk("err_cleared_c1", bus.err, 0);
         end
         exp_odt = prev_in && !(GATE && ws != 0 && cyc >= ws && cyc < e_done);
         chk("odt_en", odt_out, exp_odt);
         chk("move_load_excl", mv & ld, 0);
         if (ld === 1'b1) begin
            lcnt++;
            chk("load_cycle", cyc, 2);
         end
         if (mv === 1'b1) begin
            mcnt++;
            chk("move_cycle", cyc, first + (MOVE_GAP + 1) * (mcnt - 1));
            chk("move_dir", dir, e_dir);
            if (mcnt == oor_k) oor = 1'b1;
         end
         if (bus.done === 1'b1) begin
            seen_done = 1'b1;
            chk("done_cycle", cyc, e_done);
         end
         prev_in       = 1'($urandom_range(0, 1));
         odt_in        = prev_in;
         bus.req_valid = !seen_done && 1'($urandom_range(0, 1));
         bus.req_tap   = TAP_W'($urandom);
         bus.req_load  = 1'($urandom_range(0, 1));
      end
      chk("done_seen", seen_done, 1);
      chk("move_count", mcnt, e_moves);
      chk("load_count", lcnt, (rld && !over) ? 1 : 0);
      chk("cur_tap", bus.cur_tap, e_cur);
      chk("err", bus.err, e_err);
      @(negedge clk);
      oor = 1'b0;
      chk("ready_after", bus.req_ready, 1);
      chk("busy_after", bus.busy, 0);
      m_cur = e_cur;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_tap   = '0;
      bus.req_load  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_cur", bus.cur_tap, LOAD_TAP);
      chk("rst_move", mv, 0);
      chk("rst_load", ld, 0);
      chk("rst_dir", dir, 0);
      chk("rst_odt", odt_out, 0);
      rst   = 1'b0;
      m_cur = LOAD_TAP;

      run_req(5, 1'b0, 0);
      run_req(0, 1'b1, 0);
      run_req(10, 1'b0, 3);
      run_req(20, 1'b0, 0);
      run_req(200, 1'b0, 0);
      run_req(m_cur, 1'b0, 0);
      run_req(128, 1'b0, 0);
      run_req(LOAD_TAP, 1'b1, 0);
      run_req(MAX_TAP, 1'b0, 0);
      run_req(0, 1'b0, 0);
      run_req(LOAD_TAP, 1'b0, 0);

      // Reset between the 2nd and 3rd MOVE of a 6-tap request
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_tap   = TAP_W'(m_cur + 6);
      bus.req_load  = 1'b0;
      odt_in        = 1'b1;
      @(posedge clk);
      c = 0; moves = 0;
      while (moves < 2 && c < 100) begin
         @(negedge clk);
         c++;
         bus.req_valid = 1'b0;
         if (mv === 1'b1) moves++;
      end
      chk("rst_mid_pre_moves", moves, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_cur", bus.cur_tap, LOAD_TAP);
      chk("rst_mid_ready", bus.req_ready, 1);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_err", bus.err, 0);
      moves = 0;
      repeat (30) begin
         @(negedge clk);
         if (mv === 1'b1 || ld === 1'b1) moves++;
      end
      chk("rst_mid_no_pulses", moves, 0);
      m_cur = LOAD_TAP;

      for (int i = 0; i < 25; i++) begin
         int t, k;
         bit l;
         t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 255)) : int'($urandom_range(0, 127));
         l = ($urandom_range(0, 2) == 0);
         k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_req(t, l, k);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
